// File: rtl/eth_rx_mac.sv
// Receive MAC: strips preamble/SFD, writes frame bytes into the frame buffer and
// reports CRC / length / address status with a single strobe per frame.
module eth_rx_mac #(
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64,
  parameter int AW      = 11
) (
  input  logic          i_rx_clk,
  input  logic          i_rx_rst,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_data,
  input  logic [47:0]   i_mac_addr,
  input  logic          i_promisc,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_wr_data,
  output logic          o_frame_done,
  output logic [AW:0]   o_frame_len,
  output logic          o_frame_ok,
  output logic          o_err_crc,
  output logic          o_err_len,
  output logic          o_err_addr,
  output logic [15:0]   o_good_cnt,
  output logic [15:0]   o_bad_cnt
);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);
  localparam logic [CW-1:0] LEN_SAT = CW'(MAX_LEN + 1);
  localparam logic [CW-1:0] LEN_MIN = CW'(MIN_LEN);
  localparam logic [CW-1:0] DA_LEN  = CW'(6);
  localparam logic [31:0]   RESIDUE = 32'hC704DD7B;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_DONE, S_DROP} state_t;
  state_t state, state_nx;

  logic [CW-1:0] cnt;
  logic [31:0]   crc;
  logic          da_miss, bc_miss;
  logic          sfd_hit, take, finish, tally;
  logic [7:0]    da_byte;
  logic          crc_err, len_err, addr_err;

  // Reflected CRC-32 byte update (LSB-first, poly 0x04C11DB7 reversed).
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] c);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
    if (i_rx_rst) state <= S_IDLE;
    else          state <= state_nx;
  end

  // DONE also watches for 0x55 so a one-cycle inter-frame gap is enough.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (i_rx_dv && i_rx_data == 8'h55) state_nx = S_PRE;
      S_PRE: begin
        if (!i_rx_dv)                 state_nx = S_IDLE;
        else if (i_rx_data == 8'hD5)  state_nx = S_DATA;
        else if (i_rx_data != 8'h55)  state_nx = S_DROP;
      end
      S_DATA: if (!i_rx_dv) state_nx = S_DONE;
      S_DONE: state_nx = (i_rx_dv && i_rx_data == 8'h55) ? S_PRE : S_IDLE;
      S_DROP: if (!i_rx_dv) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    sfd_hit = 1'b0;
    take    = 1'b0;
    finish  = 1'b0;
    tally   = 1'b0;
    case (state)
      S_PRE:  sfd_hit = i_rx_dv && (i_rx_data == 8'hD5);
      S_DATA: begin
        take   = i_rx_dv;
        finish = !i_rx_dv;
      end
      S_DONE: tally = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (cnt[2:0])
      3'd0:    da_byte = i_mac_addr[47:40];
      3'd1:    da_byte = i_mac_addr[39:32];
      3'd2:    da_byte = i_mac_addr[31:24];
      3'd3:    da_byte = i_mac_addr[23:16];
      3'd4:    da_byte = i_mac_addr[15:8];
      default: da_byte = i_mac_addr[7:0];
    endcase
  end

  // The register is kept reflected; its bit-reversed form is checked against the residue.
  assign crc_err  = bit_rev(crc) != RESIDUE;
  assign len_err  = (cnt < LEN_MIN) || (cnt > LEN_MAX);
  assign addr_err = (da_miss && bc_miss && !i_promisc) || (cnt < DA_LEN);

  // o_wr_en qualifies o_wr_addr/o_wr_data for one cycle; there is no backpressure.
  always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      cnt          <= '0;
      crc          <= '1;
      da_miss      <= 1'b0;
      bc_miss      <= 1'b0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_len  <= '0;
      o_frame_ok   <= 1'b0;
      o_err_crc    <= 1'b0;
      o_err_len    <= 1'b0;
      o_err_addr   <= 1'b0;
      o_good_cnt   <= '0;
      o_bad_cnt    <= '0;
    end else begin
      o_wr_en      <= take && (cnt < LEN_MAX);
      o_frame_done <= finish;
      if (sfd_hit) begin
        cnt     <= '0;
        crc     <= '1;
        da_miss <= 1'b0;
        bc_miss <= 1'b0;
      end
      if (take) begin
        crc <= crc_next(crc, i_rx_data);
        if (cnt != LEN_SAT) cnt <= cnt + 1'b1;
        if (cnt < LEN_MAX) begin
          o_wr_addr <= cnt[AW-1:0];
          o_wr_data <= i_rx_data;
        end
        if (cnt < DA_LEN) begin
          if (i_rx_data != da_byte) da_miss <= 1'b1;
          if (i_rx_data != 8'hFF)   bc_miss <= 1'b1;
        end
      end
      if (finish) begin
        o_frame_len <= cnt;
        o_err_crc   <= crc_err;
        o_err_len   <= len_err;
        o_err_addr  <= addr_err;
        o_frame_ok  <= !(crc_err || len_err || addr_err);
      end
      if (tally) begin
        if (o_frame_ok) o_good_cnt <= o_good_cnt + 16'd1;
        else            o_bad_cnt  <= o_bad_cnt + 16'd1;
      end
    end
  end
endmodule
